dma_stream_engine: RTL and testbench

Parametrised, CSR-programmed DMA engine moving word data between Wishbone memory and the user-project AXI-Stream datapath (FIR and similar accelerators). One Wishbone master port is shared by an MM2S channel (memory read → FIFO → `ss_*`) and an S2MM channel (`sm_*` → memory write). Software programs source, destination and length through a Wishbone slave CSR window, then sets start. The engine replaces fixed-address, fixed-count sequencing with arbitrary lengths, independent channel enables and a done/busy status.

---
 rtl/dma_pkg.sv | 26 ++
 rtl/dma_fifo.sv | 55 +++++
 rtl/dma_stream_engine.sv | 270 +++++++++++++++++++++++++++
 tb/tb_dma_stream_engine.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// dma_pkg: shared constants and types for dma_stream_engine.
// CSR map, CTRL/STATUS bit positions and master FSM states.
package dma_pkg;

  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_STATUS = 5'h04;
  localparam logic [4:0] OFF_SRC    = 5'h08;
  localparam logic [4:0] OFF_DST    = 5'h0C;
  localparam logic [4:0] OFF_LEN    = 5'h10;

  localparam int WIN_LSB = 5;

  localparam int CTRL_START = 0;
  localparam int CTRL_MM2S  = 1;
  localparam int CTRL_S2MM  = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR
  } mst_state_e;

endpackage

// File: rtl/dma_fifo.sv
// dma_fifo: small synchronous FIFO buffering MM2S read data.
// Push into a full FIFO is accepted only together with a pop.
module dma_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic                  pop_i,
  output logic [DATA_W-1:0]     data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q;
  logic [AW-1:0]     rptr_q;
  logic [AW:0]       cnt_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/dma_stream_engine.sv
// dma_stream_engine: CSR-programmed DMA moving words between a
// Wishbone master port and the MM2S/S2MM AXI-Stream datapath.
module dma_stream_engine
  import dma_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                LEN_W      = 12,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] CSR_BASE   = 32'h3800_0300
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [DATA_W/8-1:0] wbs_sel_i,
  input  logic [ADDR_W-1:0]   wbs_adr_i,
  input  logic [DATA_W-1:0]   wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [DATA_W-1:0]   wbs_dat_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  output logic [ADDR_W-1:0]   wbm_adr_o,
  output logic [DATA_W-1:0]   wbm_dat_o,
  input  logic                wbm_ack_i,
  input  logic [DATA_W-1:0]   wbm_dat_i,
  output logic                ss_tvalid,
  input  logic                ss_tready,
  output logic [DATA_W-1:0]   ss_tdata,
  input  logic                sm_tvalid,
  output logic                sm_tready,
  input  logic [DATA_W-1:0]   sm_tdata,
  output logic                irq_o
);

  localparam int STRB  = DATA_W / 8;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_CNT = FIFO_DEPTH[CNT_W-1:0];
  localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(STRB);

  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] new_v,
    input logic [STRB-1:0]   sel
  );
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int b = 0; b < STRB; b++)
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  mst_state_e        state_q, state_d;
  logic              mm2s_en_q, mm2s_en_d;
  logic              s2mm_en_q, s2mm_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              irq_q, irq_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [LEN_W-1:0]  rd_left_q, rd_left_d;
  logic [LEN_W-1:0]  wr_left_q, wr_left_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              ack_q;
  logic [DATA_W-1:0] rdat_q, rdat_d;

  logic [ADDR_W-1:0] csr_off;
  logic [4:0]        reg_off;
  logic              in_win;
  logic              req;
  logic              start;
  logic [DATA_W-1:0] rdata;

  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [DATA_W-1:0] fifo_dout;
  logic              rd_room;
  logic              done_cond;

  assign csr_off = wbs_adr_i - CSR_BASE;
  assign in_win  = (csr_off[ADDR_W-1:WIN_LSB] == '0);
  assign reg_off = csr_off[WIN_LSB-1:0];
  assign req     = wbs_stb_i & wbs_cyc_i & in_win & ~ack_q;

  always_comb begin
    rdata = '0;
    unique case (reg_off)
      OFF_CTRL: begin
        rdata[CTRL_MM2S] = mm2s_en_q;
        rdata[CTRL_S2MM] = s2mm_en_q;
      end
      OFF_STATUS: begin
        rdata[STAT_BUSY] = busy_q;
        rdata[STAT_DONE] = done_q;
      end
      OFF_SRC: rdata = DATA_W'(src_q);
      OFF_DST: rdata = DATA_W'(dst_q);
      OFF_LEN: rdata = DATA_W'(len_q);
      default: rdata = '0;
    endcase
  end

  // Programming registers freeze while a transfer runs; START is a pulse.
  always_comb begin
    mm2s_en_d = mm2s_en_q;
    s2mm_en_d = s2mm_en_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    start     = 1'b0;
    rdat_d    = (req & ~wbs_we_i) ? rdata : '0;
    if (req && wbs_we_i) begin
      unique case (reg_off)
        OFF_CTRL: if (wbs_sel_i[0]) begin
          start = wbs_dat_i[CTRL_START];
          if (!busy_q) begin
            mm2s_en_d = wbs_dat_i[CTRL_MM2S];
            s2mm_en_d = wbs_dat_i[CTRL_S2MM];
          end
        end
        OFF_SRC: if (!busy_q)
          src_d = ADDR_W'(merge(DATA_W'(src_q), wbs_dat_i, wbs_sel_i));
        OFF_DST: if (!busy_q)
          dst_d = ADDR_W'(merge(DATA_W'(dst_q), wbs_dat_i, wbs_sel_i));
        OFF_LEN: if (!busy_q)
          len_d = LEN_W'(merge(DATA_W'(len_q), wbs_dat_i, wbs_sel_i));
        default: ;
      endcase
    end
  end

  assign rd_room   = (rd_left_q != '0) && !fifo_full
                     && (fifo_cnt < DEPTH_CNT);
  assign done_cond = busy_q && (rd_left_q == '0) && fifo_empty
                     && (state_q == ST_IDLE) && (wr_left_q == '0)
                     && !hold_full_q;
  assign sm_tready = busy_q & ~hold_full_q
                     & (wr_left_q > LEN_W'(hold_full_q));
  assign pop       = ss_tvalid & ss_tready;

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    rd_left_d   = rd_left_q;
    wr_left_d   = wr_left_q;
    busy_d      = busy_q;
    done_d      = done_q;
    irq_d       = 1'b0;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    push        = 1'b0;
    if (start && !busy_q) begin
      busy_d    = 1'b1;
      done_d    = 1'b0;
      rd_addr_d = src_q;
      wr_addr_d = dst_q;
      rd_left_d = mm2s_en_d ? len_q : '0;
      wr_left_d = s2mm_en_d ? len_q : '0;
    end else if (done_cond) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      irq_d  = 1'b1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (hold_full_q)  state_d = ST_WR;
        else if (rd_room) state_d = ST_RD;
      end
      ST_RD: if (wbm_ack_i) begin
        push      = 1'b1;
        rd_addr_d = rd_addr_q + STRIDE;
        rd_left_d = rd_left_q - LEN_W'(1);
        state_d   = ST_IDLE;
      end
      ST_WR: if (wbm_ack_i) begin
        hold_full_d = 1'b0;
        wr_addr_d   = wr_addr_q + STRIDE;
        wr_left_d   = wr_left_q - LEN_W'(1);
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (sm_tvalid && sm_tready) begin
      hold_d      = sm_tdata;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q     <= ST_IDLE;
      mm2s_en_q   <= 1'b0;
      s2mm_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      irq_q       <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      rd_left_q   <= '0;
      wr_left_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ack_q       <= 1'b0;
      rdat_q      <= '0;
    end else begin
      state_q     <= state_d;
      mm2s_en_q   <= mm2s_en_d;
      s2mm_en_q   <= s2mm_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      irq_q       <= irq_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      rd_left_q   <= rd_left_d;
      wr_left_q   <= wr_left_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ack_q       <= req;
      rdat_q      <= rdat_d;
    end
  end

  dma_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_i),
    .push_i (push),
    .data_i (wbm_dat_i),
    .pop_i  (pop),
    .data_o (fifo_dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_cnt)
  );

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;
  assign irq_o     = irq_q;
  assign ss_tvalid = ~fifo_empty;
  assign ss_tdata  = fifo_dout;

  // Address and data are registered state, stable for the whole cycle.
  assign wbm_cyc_o = (state_q != ST_IDLE);
  assign wbm_stb_o = (state_q != ST_IDLE);
  assign wbm_we_o  = (state_q == ST_WR);
  assign wbm_sel_o = wbm_cyc_o ? '1 : '0;
  assign wbm_adr_o = (state_q == ST_RD) ? rd_addr_q :
                     (state_q == ST_WR) ? wr_addr_q : '0;
  assign wbm_dat_o = (state_q == ST_WR) ? hold_q : '0;

endmodule

// File: tb/tb_dma_stream_engine.sv
// tb_dma_stream_engine: directed checks of CSR access, MM2S, S2MM
// loopback, zero-length starts and mid-transfer reset.
module tb_dma_stream_engine;

  localparam logic [31:0] BASE   = 32'h3800_0300;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_STAT = BASE + 32'h04;
  localparam logic [31:0] A_SRC  = BASE + 32'h08;
  localparam logic [31:0] A_DST  = BASE + 32'h0C;
  localparam logic [31:0] A_LEN  = BASE + 32'h10;
  localparam logic [31:0] SRC0   = 32'h3800_0100;
  localparam logic [31:0] DST0   = 32'h3800_0200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wbs_stb = 1'b0, wbs_cyc = 1'b0, wbs_we = 1'b0;
  logic [3:0]  wbs_sel = '0;
  logic [31:0] wbs_adr = '0, wbs_dat_w = '0;
  logic        wbs_ack;
  logic [31:0] wbs_dat_r;
  logic        wbm_cyc, wbm_stb, wbm_we;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_adr, wbm_dat_w;
  logic        wbm_ack = 1'b0;
  logic [31:0] wbm_dat_r = '0;
  logic        ss_tvalid, ss_tready;
  logic [31:0] ss_tdata;
  logic        sm_tvalid, sm_tready;
  logic [31:0] sm_tdata;
  logic        irq;
  logic        loop_en = 1'b0, rdy = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign ss_tready = loop_en ? sm_tready : rdy;
  assign sm_tvalid = loop_en & ss_tvalid;
  assign sm_tdata  = ss_tdata;

  dma_stream_engine dut (
    .wb_clk_i (clk),       .wb_rst_i (rst_n),
    .wbs_stb_i(wbs_stb),   .wbs_cyc_i(wbs_cyc),
    .wbs_we_i (wbs_we),    .wbs_sel_i(wbs_sel),
    .wbs_adr_i(wbs_adr),   .wbs_dat_i(wbs_dat_w),
    .wbs_ack_o(wbs_ack),   .wbs_dat_o(wbs_dat_r),
    .wbm_cyc_o(wbm_cyc),   .wbm_stb_o(wbm_stb),
    .wbm_we_o (wbm_we),    .wbm_sel_o(wbm_sel),
    .wbm_adr_o(wbm_adr),   .wbm_dat_o(wbm_dat_w),
    .wbm_ack_i(wbm_ack),   .wbm_dat_i(wbm_dat_r),
    .ss_tvalid(ss_tvalid), .ss_tready(ss_tready),
    .ss_tdata (ss_tdata),
    .sm_tvalid(sm_tvalid), .sm_tready(sm_tready),
    .sm_tdata (sm_tdata),
    .irq_o    (irq)
  );

  // Memory word at SRC0 + 4*i holds i.
  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a - SRC0) >> 2;
  endfunction

  logic [31:0] rd_log[$];
  logic [31:0] wr_adr_log[$];
  logic [31:0] wr_dat_log[$];
  logic [31:0] stream_q[$];
  int irq_cnt = 0, cyc_cnt = 0, cyc_no = 0, arb_viol = 0, pend_cyc = 0;
  logic pend = 1'b0;

  always @(posedge clk) begin
    cyc_no <= cyc_no + 1;
    if (wbm_cyc) cyc_cnt <= cyc_cnt + 1;
    if (irq) irq_cnt <= irq_cnt + 1;
    if (ss_tvalid && ss_tready) stream_q.push_back(ss_tdata);
    if (sm_tvalid && sm_tready && !pend) begin
      pend <= 1'b1;
      pend_cyc <= cyc_no;
    end
    if (wbm_cyc && wbm_stb && !wbm_ack) begin
      wbm_ack <= 1'b1;
      if (wbm_we) begin
        wr_adr_log.push_back(wbm_adr);
        wr_dat_log.push_back(wbm_dat_w);
        pend <= 1'b0;
      end else begin
        wbm_dat_r <= memval(wbm_adr);
        rd_log.push_back(wbm_adr);
        if (pend && pend_cyc < cyc_no - 1) arb_viol <= arb_viol + 1;
      end
    end else begin
      wbm_ack <= 1'b0;
      wbm_dat_r <= '0;
    end
  end

  task automatic csr_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    int n = 0;
    @(negedge clk);
    wbs_stb = 1; wbs_cyc = 1; wbs_we = 1;
    wbs_adr = a; wbs_dat_w = d; wbs_sel = s;
    do begin @(negedge clk); n++; end while (!wbs_ack && n < 8);
    total++;
    if (!wbs_ack) begin
      bad++;
      $display("FAIL csr_write_ack adr=%h got=0 exp=1", a);
    end
    wbs_stb = 0; wbs_cyc = 0; wbs_we = 0;
  endtask

  task automatic csr_read(input logic [31:0] a, output logic [31:0] d);
    int n = 0;
    @(negedge clk);
    wbs_stb = 1; wbs_cyc = 1; wbs_we = 0;
    wbs_adr = a; wbs_sel = 4'hF;
    do begin @(negedge clk); n++; end while (!wbs_ack && n < 8);
    total++;
    if (!wbs_ack) begin
      bad++;
      $display("FAIL csr_read_ack adr=%h got=0 exp=1", a);
    end
    d = wbs_dat_r;
    wbs_stb = 0; wbs_cyc = 0;
  endtask

  task automatic wait_irq(input int ib, input int lim, input string nm);
    int n = 0;
    while (irq_cnt == ib && n < lim) begin @(negedge clk); n++; end
    total++;
    if (irq_cnt == ib) begin
      bad++;
      $display("FAIL %s_timeout irq_cnt=%0d exp>%0d", nm, irq_cnt, ib);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({wbm_cyc, wbm_stb, wbm_we, wbm_sel, wbs_ack, ss_tvalid,
         sm_tready, irq} !== 11'd0) begin
      bad++;
      $display("FAIL rst_ctl got=%b exp=0", {wbm_cyc, wbm_stb, wbm_we,
               wbm_sel, wbs_ack, ss_tvalid, sm_tready, irq});
    end
    total++;
    if ({wbm_adr, wbm_dat_w, wbs_dat_r, ss_tdata} !== 128'd0) begin
      bad++;
      $display("FAIL rst_data adr=%h dat=%h wbs=%h ss=%h exp=0",
               wbm_adr, wbm_dat_w, wbs_dat_r, ss_tdata);
    end
    rst_n = 1;
    csr_read(A_STAT, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL rst_status got=%h exp=0", d); end
    csr_read(A_SRC, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL rst_src got=%h exp=0", d); end
  endtask

  task automatic test_csr();
    logic [31:0] d;
    bit seen = 0;
    csr_write(A_SRC, SRC0, 4'hF);
    csr_write(A_LEN, 32'd11, 4'hF);
    csr_read(A_SRC, d);
    total++;
    if (d !== SRC0) begin bad++; $display("FAIL csr_src got=%h exp=%h", d, SRC0); end
    csr_read(A_LEN, d);
    total++;
    if (d !== 32'd11) begin bad++; $display("FAIL csr_len got=%h exp=b", d); end
    csr_write(A_SRC, 32'hFFFF_FF55, 4'b0001);
    csr_read(A_SRC, d);
    total++;
    if (d !== 32'h3800_0155) begin
      bad++; $display("FAIL csr_sel got=%h exp=38000155", d);
    end
    csr_write(A_SRC, SRC0, 4'hF);
    csr_write(A_DST, DST0, 4'hF);
    csr_read(A_DST, d);
    total++;
    if (d !== DST0) begin bad++; $display("FAIL csr_dst got=%h exp=%h", d, DST0); end
    @(negedge clk);
    wbs_stb = 1; wbs_cyc = 1; wbs_we = 0; wbs_adr = BASE + 32'h100;
    repeat (4) begin @(negedge clk); if (wbs_ack) seen = 1; end
    wbs_stb = 0; wbs_cyc = 0;
    total++;
    if (seen) begin bad++; $display("FAIL csr_outside_ack got=1 exp=0"); end
  endtask

  task automatic test_mm2s();
    logic [31:0] d;
    int rb = rd_log.size(), sb = stream_q.size();
    int wb = wr_adr_log.size(), ib = irq_cnt;
    loop_en = 0; rdy = 1;
    csr_write(A_CTRL, 32'h3, 4'hF);
    wait_irq(ib, 400, "mm2s");
    repeat (3) @(negedge clk);
    total++;
    if (rd_log.size() - rb != 11) begin
      bad++; $display("FAIL mm2s_reads got=%0d exp=11", rd_log.size() - rb);
    end
    for (int i = 0; i < 11 && rb + i < rd_log.size(); i++) begin
      total++;
      if (rd_log[rb+i] !== SRC0 + 32'(4*i)) begin
        bad++; $display("FAIL mm2s_addr%0d got=%h exp=%h", i, rd_log[rb+i], SRC0 + 32'(4*i));
      end
    end
    total++;
    if (stream_q.size() - sb != 11) begin
      bad++; $display("FAIL mm2s_beats got=%0d exp=11", stream_q.size() - sb);
    end
    for (int i = 0; i < 11 && sb + i < stream_q.size(); i++) begin
      total++;
      if (stream_q[sb+i] !== 32'(i)) begin
        bad++; $display("FAIL mm2s_data%0d got=%h exp=%h", i, stream_q[sb+i], i);
      end
    end
    total++;
    if (irq_cnt - ib != 1 || wr_adr_log.size() != wb) begin
      bad++; $display("FAIL mm2s_irq_wr irq=%0d wr=%0d exp=1,0", irq_cnt - ib, wr_adr_log.size() - wb);
    end
    csr_read(A_STAT, d);
    total++;
    if (d !== 32'h2) begin bad++; $display("FAIL mm2s_status got=%h exp=2", d); end
  endtask

  task automatic test_stall();
    logic [31:0] d;
    int rb = rd_log.size(), sb = stream_q.size(), ib = irq_cnt;
    loop_en = 0; rdy = 0;
    csr_write(A_CTRL, 32'h3, 4'hF);
    repeat (60) @(negedge clk);
    total++;
    if (rd_log.size() - rb != 4 || wbm_cyc !== 1'b0 || ss_tvalid !== 1'b1) begin
      bad++; $display("FAIL stall_reads got=%0d cyc=%b vld=%b exp=4,0,1", rd_log.size() - rb, wbm_cyc, ss_tvalid);
    end
    csr_read(A_STAT, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL stall_status got=%h exp=1", d); end
    csr_write(A_LEN, 32'd5, 4'hF);
    csr_read(A_LEN, d);
    total++;
    if (d !== 32'd11) begin bad++; $display("FAIL busy_len got=%h exp=b", d); end
    csr_write(A_CTRL, 32'h3, 4'hF);
    rdy = 1;
    wait_irq(ib, 400, "stall");
    repeat (20) @(negedge clk);
    total++;
    if (rd_log.size() - rb != 11 || irq_cnt - ib != 1) begin
      bad++; $display("FAIL stall_total reads=%0d irq=%0d exp=11,1", rd_log.size() - rb, irq_cnt - ib);
    end
    for (int i = 0; i < 11 && sb + i < stream_q.size(); i++) begin
      total++;
      if (stream_q[sb+i] !== 32'(i)) begin
        bad++; $display("FAIL stall_data%0d got=%h exp=%h", i, stream_q[sb+i], i);
      end
    end
  endtask

  task automatic test_len0();
    logic [31:0] d;
    int cb, ib;
    csr_write(A_LEN, 32'd0, 4'hF);
    cb = cyc_cnt; ib = irq_cnt;
    csr_write(A_CTRL, 32'h3, 4'hF);
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL len0_irq got=%b exp=1", irq); end
    csr_read(A_STAT, d);
    total++;
    if (d !== 32'h2 || cyc_cnt != cb || irq_cnt - ib != 1) begin
      bad++; $display("FAIL len0_done st=%h cyc=%0d irq=%0d exp=2,0,1", d, cyc_cnt - cb, irq_cnt - ib);
    end
    csr_write(A_LEN, 32'd11, 4'hF);
    cb = cyc_cnt;
    csr_write(A_CTRL, 32'h1, 4'hF);
    @(negedge clk);
    total++;
    if (irq !== 1'b1 || cyc_cnt != cb) begin
      bad++; $display("FAIL noch_done irq=%b cyc=%0d exp=1,0", irq, cyc_cnt - cb);
    end
  endtask

  task automatic test_loopback();
    logic [31:0] d;
    int rb = rd_log.size(), wb = wr_adr_log.size(), ib = irq_cnt;
    csr_write(A_LEN, 32'd64, 4'hF);
    loop_en = 1;
    csr_write(A_CTRL, 32'h7, 4'hF);
    wait_irq(ib, 3000, "loop");
    repeat (3) @(negedge clk);
    total++;
    if (rd_log.size() - rb != 64 || wr_adr_log.size() - wb != 64) begin
      bad++; $display("FAIL loop_counts rd=%0d wr=%0d exp=64,64", rd_log.size() - rb, wr_adr_log.size() - wb);
    end
    for (int i = 0; i < 64 && wb + i < wr_adr_log.size(); i++) begin
      total++;
      if (wr_adr_log[wb+i] !== DST0 + 32'(4*i) || wr_dat_log[wb+i] !== 32'(i)) begin
        bad++; $display("FAIL loop_wr%0d adr=%h dat=%h exp=%h,%h", i, wr_adr_log[wb+i], wr_dat_log[wb+i], DST0 + 32'(4*i), i);
      end
    end
    total++;
    if (arb_viol != 0) begin bad++; $display("FAIL loop_arb got=%0d exp=0", arb_viol); end
    csr_read(A_STAT, d);
    total++;
    if (d !== 32'h2 || irq_cnt - ib != 1) begin
      bad++; $display("FAIL loop_status st=%h irq=%0d exp=2,1", d, irq_cnt - ib);
    end
    loop_en = 0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int n = 0;
    rdy = 1;
    csr_write(A_LEN, 32'd11, 4'hF);
    csr_write(A_CTRL, 32'h3, 4'hF);
    while (!wbm_cyc && n < 20) begin @(negedge clk); n++; end
    total++;
    if (!wbm_cyc) begin bad++; $display("FAIL rmid_cyc got=0 exp=1"); end
    rst_n = 0;
    @(negedge clk);
    total++;
    if (wbm_cyc !== 1'b0 || wbm_stb !== 1'b0 || ss_tvalid !== 1'b0) begin
      bad++; $display("FAIL rmid_abort cyc=%b stb=%b vld=%b exp=0", wbm_cyc, wbm_stb, ss_tvalid);
    end
    @(negedge clk);
    rst_n = 1;
    csr_read(A_STAT, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL rmid_status got=%h exp=0", d); end
    csr_read(A_LEN, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL rmid_len got=%h exp=0", d); end
  endtask

  initial begin
    test_reset();
    test_csr();
    test_mm2s();
    test_stall();
    test_len0();
    csr_write(A_SRC, SRC0, 4'hF);
    csr_write(A_DST, DST0, 4'hF);
    test_loopback();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
